// File: rtl/zero_detector_pkg.sv
// Shared dual-rail (NULL convention) encoding and rail-pair helpers for the
// zero detector. A rail pair is packed as {t, f}.
package zero_detector_pkg;

   localparam logic [1:0] RAIL_NULL = 2'b00;
   localparam logic [1:0] RAIL_D0   = 2'b01;
   localparam logic [1:0] RAIL_D1   = 2'b10;
   localparam logic [1:0] RAIL_ILL  = 2'b11;

   localparam int unsigned NUM_PAIRS = 4;

   // Output register tracks which wavefront it currently presents.
   typedef enum logic {
      ST_NULL = 1'b0,
      ST_DATA = 1'b1
   } out_state_e;

   function automatic logic is_data(input logic [1:0] pair);
      return (pair == RAIL_D0) || (pair == RAIL_D1);
   endfunction

   function automatic logic is_null(input logic [1:0] pair);
      return (pair == RAIL_NULL);
   endfunction

   function automatic logic is_one(input logic [1:0] pair);
      return (pair == RAIL_D1);
   endfunction

   function automatic logic is_illegal(input logic [1:0] pair);
      return (pair == RAIL_ILL);
   endfunction

endpackage

// File: rtl/zero_detector_dr_pair_classify.sv
// Classifies one dual-rail pair into data / null / one / illegal flags.
module dr_pair_classify
   import zero_detector_pkg::*;
(
   input  logic rail_t,
   input  logic rail_f,
   output logic data_o,
   output logic null_o,
   output logic one_o,
   output logic ill_o
);

   logic [1:0] pair_s;

   assign pair_s = {rail_t, rail_f};

   // Decode the pair through the shared encoding helpers.
   always_comb begin
      data_o = is_data(pair_s);
      null_o = is_null(pair_s);
      one_o  = is_one(pair_s);
      ill_o  = is_illegal(pair_s);
   end

endmodule

// File: rtl/zero_detector.sv
// Clocked dual-rail 4-input zero detector: completion detection, NULL/DATA
// alternation with hysteresis, registered dual-rail zero flag and a sticky
// illegal-encoding flag.
module zero_detector
   import zero_detector_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic E1_t,
   input  logic E1_f,
   input  logic E2_t,
   input  logic E2_f,
   input  logic E3_t,
   input  logic E3_f,
   input  logic E4_t,
   input  logic E4_f,
   output logic zero_t,
   output logic zero_f,
   output logic complete,
   output logic illegal
);

   logic [NUM_PAIRS-1:0] rail_t_s;
   logic [NUM_PAIRS-1:0] rail_f_s;
   logic [NUM_PAIRS-1:0] data_s;
   logic [NUM_PAIRS-1:0] null_s;
   logic [NUM_PAIRS-1:0] one_s;
   logic [NUM_PAIRS-1:0] ill_s;

   logic all_data_s;
   logic all_null_s;
   logic any_one_s;
   logic any_ill_s;

   out_state_e state_q, state_d;
   logic       zero_t_q, zero_t_d;
   logic       zero_f_q, zero_f_d;
   logic       complete_q, complete_d;
   logic       illegal_q, illegal_d;

   // E1 is the MSB of the input code.
   assign rail_t_s = {E1_t, E2_t, E3_t, E4_t};
   assign rail_f_s = {E1_f, E2_f, E3_f, E4_f};

   for (genvar i = 0; i < NUM_PAIRS; i++) begin : g_pair
      dr_pair_classify u_classify (
         .rail_t (rail_t_s[i]),
         .rail_f (rail_f_s[i]),
         .data_o (data_s[i]),
         .null_o (null_s[i]),
         .one_o  (one_s[i]),
         .ill_o  (ill_s[i])
      );
   end

   assign all_data_s = &data_s;
   assign all_null_s = &null_s;
   assign any_one_s  = |one_s;
   assign any_ill_s  = |ill_s;

   // Next-state: an illegal pair freezes the output; otherwise a NULL output
   // only accepts a complete DATA set and a DATA output only accepts all-NULL.
   always_comb begin
      state_d    = state_q;
      zero_t_d   = zero_t_q;
      zero_f_d   = zero_f_q;
      complete_d = complete_q;
      illegal_d  = illegal_q | any_ill_s;

      if (any_ill_s) begin
         state_d = state_q;
      end else begin
         case (state_q)
            ST_NULL: begin
               if (all_data_s) begin
                  state_d    = ST_DATA;
                  zero_t_d   = ~any_one_s;
                  zero_f_d   = any_one_s;
                  complete_d = 1'b1;
               end else begin
                  state_d = ST_NULL;
               end
            end
            ST_DATA: begin
               if (all_null_s) begin
                  state_d    = ST_NULL;
                  zero_t_d   = 1'b0;
                  zero_f_d   = 1'b0;
                  complete_d = 1'b0;
               end else begin
                  state_d = ST_DATA;
               end
            end
            default: begin
               state_d    = ST_NULL;
               zero_t_d   = 1'b0;
               zero_f_d   = 1'b0;
               complete_d = 1'b0;
            end
         endcase
      end
   end

   // Output and state registers with synchronous reset taking priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_NULL;
         zero_t_q   <= 1'b0;
         zero_f_q   <= 1'b0;
         complete_q <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         zero_t_q   <= zero_t_d;
         zero_f_q   <= zero_f_d;
         complete_q <= complete_d;
         illegal_q  <= illegal_d;
      end
   end

   assign zero_t   = zero_t_q;
   assign zero_f   = zero_f_q;
   assign complete = complete_q;
   assign illegal  = illegal_q;

endmodule

// File: tb/tb_zero_detector.sv
// Self-checking bench for zero_detector: directed scenarios plus randomized
// wavefronts compared against a behavioural model of the flag.
module tb_zero_detector;

   logic       clk;
   logic       rst;
   logic [3:0] in_t;   // bit 3 = E1 ... bit 0 = E4
   logic [3:0] in_f;
   logic       zero_t, zero_f, complete, illegal;

   int checks;
   int errors;

   // model state
   logic m_zt, m_zf, m_cmp, m_ill;

   zero_detector dut (
      .clk      (clk),
      .rst      (rst),
      .E1_t     (in_t[3]),
      .E1_f     (in_f[3]),
      .E2_t     (in_t[2]),
      .E2_f     (in_f[2]),
      .E3_t     (in_t[1]),
      .E3_f     (in_f[1]),
      .E4_t     (in_t[0]),
      .E4_f     (in_f[0]),
      .zero_t   (zero_t),
      .zero_f   (zero_f),
      .complete (complete),
      .illegal  (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: count pair kinds and apply the wavefront rules.
   function automatic void model_update();
      int n_data = 0;
      int n_null = 0;
      int n_one  = 0;
      int n_ill  = 0;
      for (int i = 0; i < 4; i++) begin
         if (in_t[i] && in_f[i]) n_ill++;
         else if (in_t[i]) begin n_data++; n_one++; end
         else if (in_f[i]) n_data++;
         else n_null++;
      end
      if (rst) begin
         m_zt = 1'b0; m_zf = 1'b0; m_cmp = 1'b0; m_ill = 1'b0;
      end else if (n_ill > 0) begin
         m_ill = 1'b1;
      end else if (!m_cmp && n_data == 4) begin
         m_cmp = 1'b1;
         m_zt  = (n_one == 0);
         m_zf  = (n_one != 0);
      end else if (m_cmp && n_null == 4) begin
         m_cmp = 1'b0; m_zt = 1'b0; m_zf = 1'b0;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic set_null();
      in_t = 4'b0000; in_f = 4'b0000;
   endtask

   task automatic set_code(input logic [3:0] code);
      in_t = code; in_f = ~code;
   endtask

   task automatic test_reset();
      rst = 1'b1; set_null();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if ({zero_t, zero_f, complete, illegal} !== 4'b0000) begin
            errors++;
            $display("FAIL reset: got zt/zf/c/i=%b required 0000",
                     {zero_t, zero_f, complete, illegal});
         end
      end
   endtask

   task automatic test_zero_data();
      set_code(4'b0000);
      tick();
      checks++;
      if ({zero_t, zero_f, complete} !== 3'b101) begin
         errors++;
         $display("FAIL zero_data: got %b required 101", {zero_t, zero_f, complete});
      end
      set_null();
      tick();
      checks++;
      if ({zero_t, zero_f, complete} !== 3'b000) begin
         errors++;
         $display("FAIL zero_null: got %b required 000", {zero_t, zero_f, complete});
      end
   endtask

   task automatic test_code_sweep();
      for (int c = 1; c < 16; c++) begin
         set_null(); tick();
         set_code(4'(c)); tick();
         checks++;
         if ({zero_t, zero_f, complete} !== 3'b011) begin
            errors++;
            $display("FAIL sweep code %0d: got %b required 011", c,
                     {zero_t, zero_f, complete});
         end
      end
      set_null(); tick();
   endtask

   task automatic test_partial();
      in_t = 4'b0000; in_f = 4'b1100;   // E1,E2 DATA0, E3,E4 NULL
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({zero_t, zero_f, complete} !== 3'b000) begin
            errors++;
            $display("FAIL partial cycle %0d: got %b required 000", i,
                     {zero_t, zero_f, complete});
         end
      end
      set_code(4'b0000); tick();
      checks++;
      if ({zero_t, zero_f, complete} !== 3'b101) begin
         errors++;
         $display("FAIL partial_complete: got %b required 101", {zero_t, zero_f, complete});
      end
   endtask

   task automatic test_hysteresis();
      // starts with DATA 1,0 held from test_partial
      in_t = 4'b0000; in_f = 4'b1110;   // E4 -> NULL
      tick();
      checks++;
      if ({zero_t, zero_f, complete} !== 3'b101) begin
         errors++;
         $display("FAIL hyst_e4_null: got %b required 101", {zero_t, zero_f, complete});
      end
      in_t = 4'b1000; in_f = 4'b0110;   // E1 -> DATA1, E4 still NULL
      tick();
      checks++;
      if ({zero_t, zero_f, complete} !== 3'b101) begin
         errors++;
         $display("FAIL hyst_e1_one: got %b required 101", {zero_t, zero_f, complete});
      end
      set_code(4'b1000);                // full DATA, different value
      tick();
      checks++;
      if ({zero_t, zero_f, complete} !== 3'b101) begin
         errors++;
         $display("FAIL hyst_new_data: got %b required 101", {zero_t, zero_f, complete});
      end
      set_null(); tick();
      checks++;
      if ({zero_t, zero_f, complete} !== 3'b000) begin
         errors++;
         $display("FAIL hyst_clear: got %b required 000", {zero_t, zero_f, complete});
      end
   endtask

   task automatic test_illegal();
      in_t = 4'b0100; in_f = 4'b1111;   // E2 illegal, others DATA0
      tick();
      checks++;
      if ({zero_t, zero_f, complete, illegal} !== 4'b0001) begin
         errors++;
         $display("FAIL illegal_set: got %b required 0001",
                  {zero_t, zero_f, complete, illegal});
      end
      set_null(); tick();
      set_code(4'b0000); tick();
      checks++;
      if ({zero_t, zero_f, complete, illegal} !== 4'b1011) begin
         errors++;
         $display("FAIL illegal_sticky: got %b required 1011",
                  {zero_t, zero_f, complete, illegal});
      end
      in_t = 4'b0010; in_f = 4'b1111;   // illegal while DATA: hold
      tick();
      set_null(); tick();
      checks++;
      if ({zero_t, zero_f, complete, illegal} !== 4'b0001) begin
         errors++;
         $display("FAIL illegal_then_null: got %b required 0001",
                  {zero_t, zero_f, complete, illegal});
      end
      rst = 1'b1; tick(); rst = 1'b0;
      checks++;
      if ({zero_t, zero_f, complete, illegal} !== 4'b0000) begin
         errors++;
         $display("FAIL illegal_reset: got %b required 0000",
                  {zero_t, zero_f, complete, illegal});
      end
   endtask

   task automatic test_illegal_hold_data();
      set_code(4'b0101); tick();
      in_t = 4'b0000; in_f = 4'b0000;
      in_t[3] = 1'b1; in_f[3] = 1'b1;   // E1 illegal, rest NULL
      tick();
      checks++;
      if ({zero_t, zero_f, complete, illegal} !== 4'b0111) begin
         errors++;
         $display("FAIL illegal_hold_data: got %b required 0111",
                  {zero_t, zero_f, complete, illegal});
      end
      rst = 1'b1; tick(); rst = 1'b0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         int r;
         r = $urandom_range(0, 19);
         if (r < 7) begin
            set_code(4'($urandom_range(0, 15)));
         end else if (r < 14) begin
            set_null();
         end else if (r < 18) begin
            for (int i = 0; i < 4; i++) begin
               int k;
               k = $urandom_range(0, 2);
               in_t[i] = (k == 2);
               in_f[i] = (k == 1);
            end
         end else if (r < 19) begin
            in_t = 4'($urandom_range(0, 15));
            in_f = 4'($urandom_range(0, 15));
         end else begin
            rst = 1'b1;
         end
         tick();
         rst = 1'b0;
         checks++;
         if ({zero_t, zero_f, complete, illegal} !== {m_zt, m_zf, m_cmp, m_ill}) begin
            errors++;
            $display("FAIL random step %0d: got zt/zf/c/i=%b required %b", n,
                     {zero_t, zero_f, complete, illegal}, {m_zt, m_zf, m_cmp, m_ill});
         end
         checks++;
         if (zero_t && zero_f) begin
            errors++;
            $display("FAIL mutex step %0d: got zt=1 zf=1 required not both", n);
         end
      end
   endtask

   initial begin
      checks = 0; errors = 0;
      m_zt = 1'b0; m_zf = 1'b0; m_cmp = 1'b0; m_ill = 1'b0;
      rst = 1'b1; set_null();
      test_reset();
      test_zero_data();
      test_code_sweep();
      test_partial();
      test_hysteresis();
      test_illegal();
      test_illegal_hold_data();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/zero_detector.md
Name: zero_detector

Overview:
- Clocked dual-rail (NULL convention) 4-input zero detector.
- Each input bit arrives as a rail pair (_t, _f); the output is a dual-rail flag that reads DATA1 when all four inputs are DATA0.
- Sits in the dual-rail datapath as a status-flag generator, e.g. zero flag of a 4-bit ALU result.
- Enforces input-completeness and NULL/DATA wavefront alternation, and registers the result on the clock.

Parameters:
- None. Width is fixed at 4 rail pairs.

Ports:
- clk     input   1  system clock, rising-edge active
- rst     input   1  synchronous, active-high reset
- E1_t    input   1  bit 1 true rail
- E1_f    input   1  bit 1 false rail
- E2_t    input   1  bit 2 true rail
- E2_f    input   1  bit 2 false rail
- E3_t    input   1  bit 3 true rail
- E3_f    input   1  bit 3 false rail
- E4_t    input   1  bit 4 true rail
- E4_f    input   1  bit 4 false rail
- zero_t  output  1  zero flag true rail (all inputs are 0)
- zero_f  output  1  zero flag false rail (some input is 1)
- complete  output  1  registered: output currently holds a DATA value
- illegal   output  1  registered, sticky: some input pair was seen as t=1,f=1

Behaviour:
- Rail-pair encoding:
  - (0,0) = NULL.
  - (0,1) = DATA0.
  - (1,0) = DATA1.
  - (1,1) = illegal.
- Reset: all outputs are registered. On a rising clk edge with rst=1: zero_t=0, zero_f=0, complete=0, illegal=0. rst has priority over all other updates.
- Per cycle, evaluate the sampled inputs:
  - all_data = every pair is DATA0 or DATA1.
  - all_null = every pair is NULL.
  - any_one = some pair is DATA1.
- Output state machine, two states tracked by the output register:
  - NULL state (zero_t=zero_f=0):
    - If all_data and no illegal pair, the next edge loads DATA: zero_t = ~any_one, zero_f = any_one, complete=1.
    - Partial DATA (some pairs NULL, some DATA) holds NULL. Hysteresis: no early completion.
  - DATA state:
    - If all_null, the next edge loads NULL: zero_t=zero_f=0, complete=0.
    - Any mix, including a changed DATA value without an intervening NULL, holds the previous DATA output unchanged.
- Latency: exactly one clk edge from a complete DATA or complete NULL input set to the output update.
- Mutual exclusion: zero_t and zero_f are never both 1.
- Illegal input handling:
  - Any pair seen as (1,1) on a clock edge sets illegal=1. It stays set until rst.
  - While any pair is illegal, the output register holds its value.
- Truth table for complete DATA input (E1..E4 as bits, E1 = MSB, for the 16 codes):
  - Code 0 (all DATA0) gives zero_t=1, zero_f=0.
  - Codes 1–15 give zero_t=0, zero_f=1.
- Input sequencing: inputs may change between any two edges. Only the values sampled at rising edges matter. No synchronizers are required; inputs are synchronous to clk.

Decomposition:
- Shared package: dual-rail encoding constants (RAIL_NULL=2'b00, RAIL_D0=2'b01, RAIL_D1=2'b10, RAIL_ILL=2'b11).
- Shared package: helper functions is_data(pair), is_null(pair), is_one(pair).
- One natural sub-module, dr_pair_classify. It takes a rail pair and produces the data/null/one/illegal flags. Instantiate it 4x.
- Top-level logic: completion reduction, state register, sticky error flag.

Test Plan:
- Reset, then all NULL for 2 cycles -> zero_t=0, zero_f=0, complete=0, illegal=0.
- NULL, then all DATA0 (each pair _t=0,_f=1) -> one edge later zero_t=1, zero_f=0, complete=1. Then all NULL -> one edge later zero_t=0, zero_f=0, complete=0.
- Sweep codes 1..15, each preceded by NULL (e.g. E1..E3 DATA0, E4 DATA1) -> zero_t=0, zero_f=1 for every code.
- Partial wavefront: from NULL, drive E1=DATA0 and E2=DATA0 with E3/E4 NULL for 3 cycles -> outputs stay 0,0. Complete E3/E4 as DATA0 -> 1,0 next edge.
- Hysteresis: from DATA output 1,0, set E4 to NULL only -> output holds 1,0. Then change E1 to DATA1 without full NULL -> still holds 1,0. Only all-NULL clears it.
- Illegal: drive E2_t=1, E2_f=1 for one cycle -> illegal=1 and the output is held. illegal remains 1 through later legal wavefronts until rst=1 clears it to 0 on the next edge.
